// File: rtl/instruction_fetcher.sv
// ---------------------------------------------------------------------------
// instruction_fetcher
//
// Read side of the instruction memory. Generates word addresses into the
// synchronous-read instruction BRAM and hands each fetched word, with its PC,
// to the decode stage. Handles decode back-pressure (stall), control-flow
// redirects (branch) and reads that collide with a loader store to the same
// address.
//
// Pipeline:
//   p0 : pc_p0 is presented to the BRAM as mem_address.
//   p1 : the read issued from p0 is in flight (fly_pc_p1 / vld_p1).
//   out: the BRAM word is captured into inst / inst_pc / inst_valid.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous, active-high
//   stall               decode cannot accept; the outputs hold
//   branch_taken        redirect fetch to branch_target this cycle
//   branch_target       redirect address
//   imem_write_enable   loader store strobe (same cycle as the BRAM write)
//   imem_write_address  loader store address
//   mem_address         BRAM read address (the pc_p0 register)
//   mem_read_data       BRAM read data, valid one cycle after mem_address
//   inst                fetched instruction word
//   inst_pc             address of inst
//   inst_valid          inst / inst_pc hold a real instruction
// ---------------------------------------------------------------------------
module instruction_fetcher #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  imem_write_enable,
    input  logic [ADDR_WIDTH-1:0] imem_write_address,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [31:0]           mem_read_data,
    output logic [31:0]           inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid
);

    // Per-edge action, in priority order.
    localparam logic [1:0] ACT_NORMAL   = 2'd0;
    localparam logic [1:0] ACT_BRANCH   = 2'd1;
    localparam logic [1:0] ACT_STALL    = 2'd2;
    localparam logic [1:0] ACT_CONFLICT = 2'd3;

    logic [ADDR_WIDTH-1:0] pc_p0;
    logic [ADDR_WIDTH-1:0] fly_pc_p1;
    logic                  vld_p1;
    logic [1:0]            act;

    // Sequential address step; wraps silently at the top of the address space.
    function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] a);
        return a + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign mem_address = pc_p0;

    always_comb begin
        act = ACT_NORMAL;
        if (branch_taken) begin
            act = ACT_BRANCH;
        end else if (stall) begin
            act = ACT_STALL;
        end else if (imem_write_enable && (imem_write_address == pc_p0)) begin
            // The word being read this cycle is being overwritten; the read
            // returns stale data, so it is dropped and pc re-presented.
            act = ACT_CONFLICT;
        end
    end

    // p0 -> p1 : address issue and in-flight tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_p0     <= RESET_PC;
            fly_pc_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            case (act)
                ACT_BRANCH: begin
                    pc_p0  <= branch_target;
                    vld_p1 <= 1'b0;
                end
                ACT_STALL: begin
                    // The in-flight word cannot be accepted, so its address is
                    // re-presented once decode is ready again.
                    if (vld_p1) begin
                        pc_p0 <= fly_pc_p1;
                    end
                    vld_p1 <= 1'b0;
                end
                ACT_CONFLICT: begin
                    vld_p1 <= 1'b0;
                end
                default: begin
                    fly_pc_p1 <= pc_p0;
                    vld_p1    <= 1'b1;
                    pc_p0     <= pc_inc(pc_p0);
                end
            endcase
        end
    end

    // p1 -> out : capture of the returned BRAM word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else begin
            case (act)
                ACT_BRANCH: begin
                    inst_valid <= 1'b0;
                end
                ACT_STALL: begin
                    // Outputs hold while decode is stalled.
                end
                default: begin
                    inst       <= mem_read_data;
                    inst_pc    <= fly_pc_p1;
                    inst_valid <= vld_p1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetcher.sv
module tb_instruction_fetcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_w;
    logic        stall, branch_taken, imem_write_enable;
    logic [15:0] branch_target, imem_write_address;
    logic [31:0] imem_write_data;

    logic [15:0] mem_address, inst_pc;
    logic [31:0] mem_read_data, inst;
    logic        inst_valid;

    logic [15:0] mem_address_w, inst_pc_w;
    logic [31:0] mem_read_data_w, inst_w;
    logic        inst_valid_w;

    int checks = 0;
    int passed = 0;

    instruction_fetcher #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_write_enable(imem_write_enable),
        .imem_write_address(imem_write_address), .mem_address(mem_address),
        .mem_read_data(mem_read_data), .inst(inst), .inst_pc(inst_pc),
        .inst_valid(inst_valid)
    );

    instruction_fetcher #(.ADDR_WIDTH(16), .RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .reset(rst_w), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_write_enable(imem_write_enable),
        .imem_write_address(imem_write_address), .mem_address(mem_address_w),
        .mem_read_data(mem_read_data_w), .inst(inst_w), .inst_pc(inst_pc_w),
        .inst_valid(inst_valid_w)
    );

    // BRAM: word i = 0x1000_0000 + i unless overwritten by the loader.
    // Read-first: a read and write of the same address on one edge returns old data.
    bit [31:0] mem_ov [bit [15:0]];
    bit [31:0] ref_ov [bit [15:0]];

    function automatic logic [31:0] bram_rd(input logic [15:0] a);
        if (mem_ov.exists(a)) return mem_ov[a];
        return 32'h1000_0000 + {16'h0000, a};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        if (ref_ov.exists(a)) return ref_ov[a];
        return 32'h1000_0000 + {16'h0000, a};
    endfunction

    always @(posedge clk) begin
        mem_read_data   <= bram_rd(mem_address);
        mem_read_data_w <= bram_rd(mem_address_w);
        if (imem_write_enable) mem_ov[imem_write_address] = imem_write_data;
    end

    // Reference model: a queue of outstanding reads, each carrying the word it
    // will return, plus the address the fetcher should present next.
    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } req_t;

    req_t        fly_q[$];
    logic [15:0] m_pc;
    logic        m_vld;
    logic [15:0] m_ipc;
    logic [31:0] m_inst;

    task automatic model_reset();
        fly_q.delete();
        m_pc   = 16'h0000;
        m_vld  = 1'b0;
        m_ipc  = 16'h0000;
        m_inst = 32'h0;
    endtask

    task automatic model_edge();
        req_t r;
        if (branch_taken) begin
            m_vld = 1'b0;
            fly_q.delete();
            m_pc = branch_target;
        end else if (stall) begin
            if (fly_q.size() > 0) begin
                r = fly_q.pop_front();
                m_pc = r.a;
            end
            fly_q.delete();
        end else begin
            if (fly_q.size() > 0) begin
                r = fly_q.pop_front();
                m_vld  = 1'b1;
                m_ipc  = r.a;
                m_inst = r.d;
            end else begin
                m_vld = 1'b0;
            end
            if (!(imem_write_enable && imem_write_address == m_pc)) begin
                r.a = m_pc;
                r.d = ref_rd(m_pc);
                fly_q.push_back(r);
                m_pc = m_pc + 16'd1;
            end
        end
        if (imem_write_enable) ref_ov[imem_write_address] = imem_write_data;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Set inputs between edges, take one rising edge, settle 1 time unit.
    task automatic apply(input logic s, input logic b, input logic [15:0] t,
                         input logic we, input logic [15:0] wa, input logic [31:0] wd);
        stall = s; branch_taken = b; branch_target = t;
        imem_write_enable = we; imem_write_address = wa; imem_write_data = wd;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
    endtask

    typedef struct {
        logic        s, b;
        logic [15:0] t;
        logic        we;
        logic [15:0] wa;
        logic [31:0] wd;
        logic [15:0] ea;
        logic        ev;
        logic [15:0] ep;
        logic [31:0] ei;
    } vec_t;

    function automatic vec_t vec(input logic s, input logic b, input logic [15:0] t,
                                 input logic we, input logic [15:0] wa, input logic [31:0] wd,
                                 input logic [15:0] ea, input logic ev, input logic [15:0] ep,
                                 input logic [31:0] ei);
        vec_t v;
        v.s = s; v.b = b; v.t = t; v.we = we; v.wa = wa; v.wd = wd;
        v.ea = ea; v.ev = ev; v.ep = ep; v.ei = ei;
        return v;
    endfunction

    vec_t tbl[23];

    initial begin
        // Sequential fetch, 3-cycle stall at inst_pc=5, branch during stall,
        // then a write conflict at 0x0020 in the middle of a flowing stream.
        tbl[0]  = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0001,0,16'h0000,32'h0);
        tbl[1]  = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0002,1,16'h0000,32'h1000_0000);
        tbl[2]  = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0003,1,16'h0001,32'h1000_0001);
        tbl[3]  = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0004,1,16'h0002,32'h1000_0002);
        tbl[4]  = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0005,1,16'h0003,32'h1000_0003);
        tbl[5]  = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0006,1,16'h0004,32'h1000_0004);
        tbl[6]  = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0007,1,16'h0005,32'h1000_0005);
        tbl[7]  = vec(1,0,16'h0,0,16'h0,32'h0, 16'h0006,1,16'h0005,32'h1000_0005);
        tbl[8]  = vec(1,0,16'h0,0,16'h0,32'h0, 16'h0006,1,16'h0005,32'h1000_0005);
        tbl[9]  = vec(1,0,16'h0,0,16'h0,32'h0, 16'h0006,1,16'h0005,32'h1000_0005);
        tbl[10] = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0007,0,16'h0000,32'h0);
        tbl[11] = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0008,1,16'h0006,32'h1000_0006);
        tbl[12] = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0009,1,16'h0007,32'h1000_0007);
        tbl[13] = vec(1,1,16'h0100,0,16'h0,32'h0, 16'h0100,0,16'h0000,32'h0);
        tbl[14] = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0101,0,16'h0000,32'h0);
        tbl[15] = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0102,1,16'h0100,32'h1000_0100);
        tbl[16] = vec(0,1,16'h001E,0,16'h0,32'h0, 16'h001E,0,16'h0000,32'h0);
        tbl[17] = vec(0,0,16'h0,0,16'h0,32'h0, 16'h001F,0,16'h0000,32'h0);
        tbl[18] = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0020,1,16'h001E,32'h1000_001E);
        tbl[19] = vec(0,0,16'h0,1,16'h0020,32'hDEAD_BEEF, 16'h0020,1,16'h001F,32'h1000_001F);
        tbl[20] = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0021,0,16'h0000,32'h0);
        tbl[21] = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0022,1,16'h0020,32'hDEAD_BEEF);
        tbl[22] = vec(0,0,16'h0,0,16'h0,32'h0, 16'h0023,1,16'h0021,32'h1000_0021);

        rst = 1'b1; rst_w = 1'b1;
        stall = 0; branch_taken = 0; branch_target = 0;
        imem_write_enable = 0; imem_write_address = 0; imem_write_data = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("reset_addr",  {16'h0, mem_address}, 32'h0);
        chk("reset_valid", {31'h0, inst_valid},  32'h0);
        chk("reset_inst",  inst,                 32'h0);
        chk("reset_pc",    {16'h0, inst_pc},     32'h0);

        #2 rst = 1'b0;
        for (int i = 0; i < 23; i++) begin
            apply(tbl[i].s, tbl[i].b, tbl[i].t, tbl[i].we, tbl[i].wa, tbl[i].wd);
            chk($sformatf("tbl%0d_addr", i),  {16'h0, mem_address}, {16'h0, tbl[i].ea});
            chk($sformatf("tbl%0d_valid", i), {31'h0, inst_valid},  {31'h0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_pc", i),   {16'h0, inst_pc}, {16'h0, tbl[i].ep});
                chk($sformatf("tbl%0d_inst", i), inst,             tbl[i].ei);
            end
        end

        // Async reset mid-cycle clears everything immediately.
        #2 rst = 1'b1;
        #1;
        chk("areset_addr",  {16'h0, mem_address}, 32'h0);
        chk("areset_valid", {31'h0, inst_valid},  32'h0);
        chk("areset_inst",  inst,                 32'h0);
        chk("areset_pc",    {16'h0, inst_pc},     32'h0);
        model_reset();
        #1 rst = 1'b0;

        // Branch to 0x0040 while inst_pc=3: two bubbles, then the target;
        // instructions 4 and 5 never appear.
        for (int i = 0; i < 5; i++) idle();
        chk("br_pre_pc", {16'h0, inst_pc}, 32'h3);
        apply(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0, 32'h0);
        chk("br_bubble1", {31'h0, inst_valid}, 32'h0);
        idle();
        chk("br_bubble2", {31'h0, inst_valid}, 32'h0);
        idle();
        chk("br_tgt_valid", {31'h0, inst_valid}, 32'h1);
        chk("br_tgt_pc",    {16'h0, inst_pc},    32'h0040);
        chk("br_tgt_inst",  inst,                32'h1000_0040);
        idle();
        chk("br_next_pc", {16'h0, inst_pc}, 32'h0041);
        chk("br_no_4_5", {31'h0, (inst_valid && (inst_pc == 16'h4 || inst_pc == 16'h5))}, 32'h0);

        // Wrap-around on the RESET_PC=0xFFFE instance, then async reset.
        #2 rst_w = 1'b0;
        idle();
        chk("wrap_addr1",  {16'h0, mem_address_w}, 32'hFFFF);
        chk("wrap_valid1", {31'h0, inst_valid_w},  32'h0);
        idle();
        chk("wrap_pc_fffe",   {16'h0, inst_pc_w}, 32'hFFFE);
        chk("wrap_inst_fffe", inst_w,             32'h1000_FFFE);
        idle();
        chk("wrap_pc_ffff",   {16'h0, inst_pc_w}, 32'hFFFF);
        chk("wrap_inst_ffff", inst_w,             32'h1000_FFFF);
        idle();
        chk("wrap_pc_0000",   {16'h0, inst_pc_w}, 32'h0000);
        chk("wrap_inst_0000", inst_w,             32'h1000_0000);
        chk("wrap_valid",     {31'h0, inst_valid_w}, 32'h1);
        #2 rst_w = 1'b1;
        #1;
        chk("wrap_rst_addr",  {16'h0, mem_address_w}, 32'hFFFE);
        chk("wrap_rst_valid", {31'h0, inst_valid_w},   32'h0);
        chk("wrap_rst_inst",  inst_w,                  32'h0);
        chk("wrap_rst_pc",    {16'h0, inst_pc_w},      32'h0);

        // Randomized traffic against the reference model.
        rst = 1'b1;
        #1;
        model_reset();
        #1 rst = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            logic        s, b, we;
            logic [15:0] t, wa;
            logic [31:0] wd;
            s  = ($urandom_range(0, 99) < 20);
            b  = ($urandom_range(0, 99) < 6);
            t  = 16'($urandom);
            we = ($urandom_range(0, 99) < 15);
            wa = ($urandom_range(0, 1) == 1) ? m_pc : 16'($urandom);
            wd = $urandom;
            apply(s, b, t, we, wa, wd);
            chk($sformatf("rnd%0d_addr", n),  {16'h0, mem_address}, {16'h0, m_pc});
            chk($sformatf("rnd%0d_valid", n), {31'h0, inst_valid},  {31'h0, m_vld});
            if (m_vld) begin
                chk($sformatf("rnd%0d_pc", n),   {16'h0, inst_pc}, {16'h0, m_ipc});
                chk($sformatf("rnd%0d_inst", n), inst,             m_inst);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
